// File: rtl/instr_sequencer_if.sv
// Issue-stage bus: program load port plus the instruction/write-enable
// stream that feeds the register file and ALU.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              start;
  logic [15:0]       instruction;
  logic              enable_write;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic              illegal;

  modport master (
    output load_en, load_addr, load_data, start,
    input  instruction, enable_write, pc, busy, done, illegal
  );

  modport slave (
    input  load_en, load_addr, load_data, start,
    output instruction, enable_write, pc, busy, done, illegal
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction-issue stage: fetches from a loadable program memory and issues
// one instruction every two cycles (ISSUE for reads, WRITE for the negedge commit).
module instr_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       mem_q [PROG_DEPTH];
  logic [15:0]       instruction_q, instruction_d;
  logic              enable_write_q, enable_write_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;

  logic              idle_like;
  logic              mem_we;
  logic [15:0]       fetch_first;
  logic [ADDR_W-1:0] pc_next;
  logic [3:0]        opcode;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign mem_we    = bus.load_en && idle_like;
  assign pc_next   = pc_q + 1'b1;
  assign opcode    = instruction_q[15:12];

  // A load to address 0 in the start cycle must be the word that gets fetched.
  assign fetch_first = (mem_we && (bus.load_addr == '0)) ? bus.load_data : mem_q[0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    instruction_d  = instruction_q;
    enable_write_d = 1'b0;
    pc_d           = pc_q;
    busy_d         = busy_q;
    done_d         = done_q;
    illegal_d      = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d       = ISSUE;
          instruction_d = fetch_first;
          pc_d          = '0;
          illegal_d     = 1'b0;
          done_d        = 1'b0;
          busy_d        = 1'b1;
        end
      end
      ISSUE: begin
        if (opcode == 4'hF) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d        = WRITE;
          enable_write_d = (opcode <= 4'd10);
          if (opcode >= 4'd11) begin
            illegal_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // The last address ends the run instead of wrapping pc.
        if (pc_q == ADDR_W'(PROG_DEPTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d       = ISSUE;
          pc_d          = pc_next;
          instruction_d = mem_q[pc_next];
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      instruction_q  <= '0;
      enable_write_q <= 1'b0;
      pc_q           <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      instruction_q  <= instruction_d;
      enable_write_q <= enable_write_d;
      pc_q           <= pc_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      illegal_q      <= illegal_d;
    end
  end

  assign bus.instruction  = instruction_q;
  assign bus.enable_write = enable_write_q;
  assign bus.pc           = pc_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a trace model built from the program contents is
// compared every cycle, plus directed literal checks and a tiny regfile/ALU.
module tb_instr_sequencer;

  typedef struct packed {
    logic [15:0] instr;
    logic        ew;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vec_count = 0;
  int   miss_count = 0;
  int   ew_count = 0;
  int   busy_cycles = 0;
  logic rf_init = 1'b0;
  logic [7:0]  rf [16];
  logic [15:0] m_mem [16];
  exp_t exp_cur = '0;
  exp_t exp_q [$];

  instr_sequencer_if #(.ADDR_W(4)) bus ();

  instr_sequencer #(.ADDR_W(4), .PROG_DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [15:0] instr, logic ew, logic [3:0] pc,
                              logic busy, logic done, logic ill);
    exp_t e;
    e.instr = instr; e.ew = ew; e.pc = pc; e.busy = busy; e.done = done; e.ill = ill;
    return e;
  endfunction

  // One run is a walk over memory: each instruction contributes an ISSUE cycle
  // and (unless HALT) a WRITE cycle, then the final DONE view is held.
  task automatic buildRun();
    logic ill;
    logic halted;
    logic [3:0] op;
    exp_q.delete();
    ill = 1'b0;
    halted = 1'b0;
    for (int a = 0; a < 16 && !halted; a++) begin
      op = m_mem[a][15:12];
      exp_q.push_back(mk(m_mem[a], 1'b0, 4'(a), 1'b1, 1'b0, ill));
      if (op == 4'hF) begin
        exp_q.push_back(mk(m_mem[a], 1'b0, 4'(a), 1'b0, 1'b1, ill));
        halted = 1'b1;
      end else begin
        if (op >= 4'd11) ill = 1'b1;
        exp_q.push_back(mk(m_mem[a], (op <= 4'd10), 4'(a), 1'b1, 1'b0, ill));
      end
    end
    if (!halted) exp_q.push_back(mk(m_mem[15], 1'b0, 4'd15, 1'b0, 1'b1, ill));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_cur = mk(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      exp_q.delete();
    end else if (exp_cur.busy) begin
      exp_cur = exp_q.pop_front();
    end else begin
      if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
      if (bus.start) begin
        buildRun();
        exp_cur = exp_q.pop_front();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model.instruction", bus.instruction, exp_cur.instr);
      checkOutput("model.enable_write", 16'(bus.enable_write), 16'(exp_cur.ew));
      checkOutput("model.pc", 16'(bus.pc), 16'(exp_cur.pc));
      checkOutput("model.busy", 16'(bus.busy), 16'(exp_cur.busy));
      checkOutput("model.done", 16'(bus.done), 16'(exp_cur.done));
      checkOutput("model.illegal", 16'(bus.illegal), 16'(exp_cur.ill));
      if (bus.enable_write) ew_count++;
      if (bus.busy) busy_cycles++;
    end
  end

  // Minimal register file: commits r[wr] = r[rs1] + r[rs2] on the negedge of a write cycle.
  always @(negedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] = 8'(i);
      rf[3] = 8'd5;
      rf[7] = 8'd1;
    end else if (rst_n && bus.enable_write && bus.instruction[15:12] == 4'h0) begin
      rf[bus.instruction[11:8]] = rf[bus.instruction[7:4]] + rf[bus.instruction[3:0]];
    end
  end

  task automatic applyStimulus(input logic le, input logic [3:0] la,
                               input logic [15:0] ld, input logic st);
    @(negedge clk);
    bus.load_en = le;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.start = st;
    @(posedge clk);
    #1;
    bus.load_en = 1'b0;
    bus.load_addr = 4'd0;
    bus.load_data = 16'h0000;
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 200 && !bus.done; i++) @(negedge clk);
    checkOutput(name, 16'(bus.done), 16'd1);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  int ew_base;
  int busy_base;

  initial begin
    bus.load_en = 1'b0;
    bus.load_addr = 4'd0;
    bus.load_data = 16'h0000;
    bus.start = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset.instruction", bus.instruction, 16'h0000);
    checkOutput("reset.busy", 16'(bus.busy), 16'd0);
    checkOutput("reset.done", 16'(bus.done), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single add then halt");
    applyStimulus(1'b1, 4'd0, 16'h0373, 1'b0);
    applyStimulus(1'b1, 4'd1, 16'hF000, 1'b0);
    @(negedge clk) rf_init = 1'b1;
    @(negedge clk) rf_init = 1'b0;
    ew_base = ew_count;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    checkOutput("t2.c1.instruction", bus.instruction, 16'h0373);
    checkOutput("t2.c1.enable_write", 16'(bus.enable_write), 16'd0);
    nextCycle();
    checkOutput("t2.c2.enable_write", 16'(bus.enable_write), 16'd1);
    nextCycle();
    checkOutput("t2.c3.instruction", bus.instruction, 16'hF000);
    checkOutput("t2.c3.pc", 16'(bus.pc), 16'd1);
    nextCycle();
    checkOutput("t2.c4.done", 16'(bus.done), 16'd1);
    checkOutput("t2.c4.busy", 16'(bus.busy), 16'd0);
    @(negedge clk);
    checkOutput("t2.writes", 16'(ew_count - ew_base), 16'd1);
    checkOutput("t6.r3", 16'(rf[3]), 16'd6);

    $display("[TB] illegal opcode run");
    applyStimulus(1'b1, 4'd0, 16'hB123, 1'b0);
    ew_base = ew_count;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    waitDone("t3.done_timeout");
    @(negedge clk);
    checkOutput("t3.illegal", 16'(bus.illegal), 16'd1);
    checkOutput("t3.writes", 16'(ew_count - ew_base), 16'd0);
    ew_base = ew_count;
    applyStimulus(1'b1, 4'd0, 16'hF000, 1'b1);
    checkOutput("t3.fetch_new_word", bus.instruction, 16'hF000);
    checkOutput("t3.illegal_cleared", 16'(bus.illegal), 16'd0);
    waitDone("t3b.done_timeout");
    @(negedge clk);
    checkOutput("t3b.writes", 16'(ew_count - ew_base), 16'd0);

    $display("[TB] full sixteen-word program");
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 4'(a), 16'h0111, 1'b0);
    ew_base = ew_count;
    busy_base = busy_cycles;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    waitDone("t4.done_timeout");
    repeat (3) @(negedge clk);
    checkOutput("t4.writes", 16'(ew_count - ew_base), 16'd16);
    checkOutput("t4.busy_cycles", 16'(busy_cycles - busy_base), 16'd32);
    checkOutput("t4.pc_no_wrap", 16'(bus.pc), 16'd15);

    $display("[TB] start and load while busy");
    ew_base = ew_count;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 4'd0, 16'hF000, 1'b1);
    waitDone("t5.done_timeout");
    @(negedge clk);
    checkOutput("t5.writes", 16'(ew_count - ew_base), 16'd16);
    ew_base = ew_count;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    waitDone("t5b.done_timeout");
    @(negedge clk);
    checkOutput("t5b.mem_unchanged", 16'(ew_count - ew_base), 16'd16);

    $display("[TB] reset during write cycle");
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10 && !bus.enable_write; i++) @(negedge clk);
    checkOutput("t1.in_write", 16'(bus.enable_write), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1.enable_write", 16'(bus.enable_write), 16'd0);
    checkOutput("t1.busy", 16'(bus.busy), 16'd0);
    checkOutput("t1.pc", 16'(bus.pc), 16'd0);
    checkOutput("t1.instruction", bus.instruction, 16'h0000);
    nextCycle();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t1.idle_done", 16'(bus.done), 16'd0);
    ew_base = ew_count;
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1);
    waitDone("t1b.done_timeout");
    @(negedge clk);
    checkOutput("t1b.mem_intact", 16'(ew_count - ew_base), 16'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
